// File: rtl/mouse_receiver_pkg.sv
// Shared definitions for the PS/2 mouse receiver.
// Contents: the receiver state enum, the default timeout value, the error-code
// bit positions, and the odd-parity helper.
package mouse_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } state_t;

    // 100 us at 50 MHz
    localparam int TIMEOUT_CYCLES_DEFAULT = 5000;

    localparam int ERR_PARITY = 0;
    localparam int ERR_STOP   = 1;

    // The PS/2 parity bit makes the total count of ones in data plus parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/mouse_receiver_ps2_edge_sync.sv
// ps2_edge_sync: brings the PS/2 clock and data lines into the system clock
// domain and produces a one-cycle pulse for each falling edge of the mouse clock.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset; all stages reset to 1 (idle bus)
//   clk_mouse   raw PS/2 clock
//   data_mouse  raw PS/2 data
//   data_sync   synchronised PS/2 data
//   clk_fall    one-cycle pulse on a falling edge of the synchronised PS/2 clock
module ps2_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_mouse,
    input  logic data_mouse,
    output logic data_sync,
    output logic clk_fall
);

    logic [SYNC_STAGES-1:0] clk_pipe;
    logic [SYNC_STAGES-1:0] data_pipe;
    logic                   clk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_pipe  <= '1;
            data_pipe <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_pipe[0]  <= clk_mouse;
            data_pipe[0] <= data_mouse;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_pipe[i]  <= clk_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
            clk_prev <= clk_pipe[SYNC_STAGES-1];
        end
    end

    assign data_sync = data_pipe[SYNC_STAGES-1];
    // Previous sample high and current sample low; rising edges produce nothing.
    assign clk_fall  = clk_prev & ~clk_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/mouse_receiver.sv
// mouse_receiver: receives 11-bit PS/2 frames (start, D0..D7, odd parity, stop)
// from a mouse and delivers each byte with its error flags.
// Ports:
//   CLK              system clock (50 MHz nominal)
//   RESET            asynchronous active-low reset
//   CLK_MOUSE_IN     PS/2 clock, idles high
//   DATA_MOUSE_IN    PS/2 data, idles high
//   READ_ENABLE      high = start bits are accepted
//   BYTE_READ        last received byte
//   BYTE_ERROR_CODE  bit0 parity error, bit1 stop-bit error
//   BYTE_READY       one-cycle strobe when BYTE_READ/BYTE_ERROR_CODE are new
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | waiting for a start bit (data 0) while READ_ENABLE is high
// ST_DATA   | shifting in D0..D7, LSB first
// ST_PARITY | sampling the parity bit and checking it
// ST_STOP   | sampling the stop bit and checking it
// ST_DONE   | publishing the byte and pulsing BYTE_READY
module mouse_receiver
    import mouse_receiver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY
);

    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t               state;
    state_t               next_state;
    logic                 data_sync;
    logic                 clk_fall;
    logic [7:0]           shift;
    logic [2:0]           bit_cnt;
    logic [1:0]           err;
    logic [TIMEOUT_W-1:0] timeout_cnt;
    logic                 timed_out;

    ps2_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (CLK),
        .rst_n      (RESET),
        .clk_mouse  (CLK_MOUSE_IN),
        .data_mouse (DATA_MOUSE_IN),
        .data_sync  (data_sync),
        .clk_fall   (clk_fall)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        // A falling edge on the same cycle as the limit still counts as activity.
        timed_out  = (state != ST_IDLE) && !clk_fall &&
                     (timeout_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
        case (state)
            ST_IDLE:   if (clk_fall && !data_sync && READ_ENABLE) next_state = ST_DATA;
            ST_DATA:   if (clk_fall && bit_cnt == 3'd7)           next_state = ST_PARITY;
            ST_PARITY: if (clk_fall)                              next_state = ST_STOP;
            ST_STOP:   if (clk_fall)                              next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
        if (timed_out) begin
            next_state = ST_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            shift           <= 8'h00;
            bit_cnt         <= 3'd0;
            err             <= 2'b00;
            timeout_cnt     <= '0;
            BYTE_READ       <= 8'h00;
            BYTE_ERROR_CODE <= 2'b00;
            BYTE_READY      <= 1'b0;
        end else begin
            BYTE_READY <= 1'b0;

            if (state == ST_IDLE || clk_fall) begin
                timeout_cnt <= '0;
            end else if (!timed_out) begin
                timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (next_state == ST_DATA) begin
                        bit_cnt <= 3'd0;
                        err     <= 2'b00;
                    end
                end
                ST_DATA: begin
                    if (clk_fall) begin
                        shift[bit_cnt] <= data_sync;
                        bit_cnt        <= bit_cnt + 3'd1;
                    end
                end
                ST_PARITY: begin
                    if (clk_fall) begin
                        err[ERR_PARITY] <= (data_sync != odd_parity(shift));
                    end
                end
                ST_STOP: begin
                    if (clk_fall) begin
                        err[ERR_STOP] <= ~data_sync;
                    end
                end
                ST_DONE: begin
                    BYTE_READ       <= shift;
                    BYTE_ERROR_CODE <= err;
                    BYTE_READY      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_receiver.sv
// Bench for mouse_receiver. Mouse timing is scaled down 100x from the real
// 80 us bit period (and the timeout with it) to keep the run short; the
// ratios between bit period, low time, data lead and timeout are preserved.
module tb_mouse_receiver;
    import mouse_receiver_pkg::*;

    localparam int BIT_HALF = 20;   // cycles CLK_MOUSE_IN is low (and high)
    localparam int LEAD     = 10;   // data changes this many cycles before a fall
    localparam int TMO      = 50;   // scaled 100 us
    localparam int IDLE_GAP = 100;  // scaled 200 us
    localparam int SYNC     = 2;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       re;
        int         exp_cnt;
        logic [7:0] exp_byte;
        logic [1:0] exp_err;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       mclk;
    logic       mdata;
    logic       re;
    logic [7:0] byte_read;
    logic [1:0] byte_err;
    logic       byte_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int ready_cnt = 0;
    int wide_cnt = 0;
    int last_ready_cyc = 0;
    int stop_fall_cyc = 0;
    logic ready_prev = 1'b0;

    mouse_receiver #(
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .CLK             (clk),
        .RESET           (rst_n),
        .CLK_MOUSE_IN    (mclk),
        .DATA_MOUSE_IN   (mdata),
        .READ_ENABLE     (re),
        .BYTE_READ       (byte_read),
        .BYTE_ERROR_CODE (byte_err),
        .BYTE_READY      (byte_ready)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_ready === 1'b1) begin
            ready_cnt++;
            last_ready_cyc = cyc;
            if (ready_prev) wide_cnt++;
        end
        ready_prev = (byte_ready === 1'b1);
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first nbits bits of a frame; READ_ENABLE drops just before
    // bit index re_drop (pass -1 to leave it alone).
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int nbits, input int re_drop);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (i == re_drop) re = 1'b0;
            wait_cyc(BIT_HALF - LEAD);
            mdata = bits[i];
            wait_cyc(LEAD);
            mclk = 1'b0;
            if (i == 10) stop_fall_cyc = cyc;
            wait_cyc(BIT_HALF);
            mclk = 1'b1;
        end
        wait_cyc(BIT_HALF - LEAD);
        mdata = 1'b1;
    endtask

    vec_t vecs[10];

    initial begin
        int cnt0;
        int lat;

        vecs[0] = '{8'hF9, 1'b1, 1'b1, 1'b1, 1, 8'hF9, 2'b00};
        vecs[1] = '{8'hF4, 1'b0, 1'b1, 1'b1, 1, 8'hF4, 2'b00};
        vecs[2] = '{8'hFA, 1'b1, 1'b1, 1'b1, 1, 8'hFA, 2'b00};
        vecs[3] = '{8'hF9, 1'b0, 1'b1, 1'b1, 1, 8'hF9, 2'b01};
        vecs[4] = '{8'hF4, 1'b0, 1'b0, 1'b1, 1, 8'hF4, 2'b10};
        vecs[5] = '{8'hF9, 1'b1, 1'b1, 1'b0, 0, 8'hF4, 2'b10};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 1, 8'h00, 2'b00};
        vecs[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 1, 8'h80, 2'b00};
        vecs[8] = '{8'h01, 1'b0, 1'b1, 1'b1, 1, 8'h01, 2'b00};
        vecs[9] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1, 8'hA5, 2'b11};

        rst_n = 1'b0;
        mclk  = 1'b1;
        mdata = 1'b1;
        re    = 1'b1;
        wait_cyc(5);
        check("reset_byte", 32'(byte_read), 32'h00);
        check("reset_err", 32'(byte_err), 32'h0);
        check("reset_ready", 32'(byte_ready), 32'h0);
        rst_n = 1'b1;
        wait_cyc(5);
        check("reset_state", 32'(dut.state), 32'(ST_IDLE));

        for (int v = 0; v < 10; v++) begin
            re   = vecs[v].re;
            cnt0 = ready_cnt;
            send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, 11, -1);
            wait_cyc(30);
            check($sformatf("vec%0d_ready_count", v), 32'(ready_cnt - cnt0), 32'(vecs[v].exp_cnt));
            check($sformatf("vec%0d_byte", v), 32'(byte_read), 32'(vecs[v].exp_byte));
            check($sformatf("vec%0d_err", v), 32'(byte_err), 32'(vecs[v].exp_err));
            if (vecs[v].exp_cnt == 1) begin
                lat = last_ready_cyc - stop_fall_cyc;
                n_tests++;
                if (lat < 1 || lat > SYNC + 3) begin
                    n_fail++;
                    $display("FAIL vec%0d_latency: got %0d cycles, required 1..%0d", v, lat, SYNC + 3);
                end
            end
        end
        re = 1'b1;

        // Reset in the middle of a frame clears outputs at once and drops the frame.
        cnt0 = ready_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 5, -1);
        wait_cyc(2);
        #5;
        rst_n = 1'b0;
        #1;
        check("midrst_byte", 32'(byte_read), 32'h00);
        check("midrst_err", 32'(byte_err), 32'h0);
        check("midrst_ready", 32'(byte_ready), 32'h0);
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(20);
        check("midrst_no_ready", 32'(ready_cnt - cnt0), 32'd0);
        send_frame(8'hF4, 1'b0, 1'b1, 11, -1);
        wait_cyc(30);
        check("postrst_ready_count", 32'(ready_cnt - cnt0), 32'd1);
        check("postrst_byte", 32'(byte_read), 32'hF4);
        check("postrst_err", 32'(byte_err), 32'h0);

        // Partial frame abandoned by the timeout, then a clean frame.
        cnt0 = ready_cnt;
        send_frame(8'h55, 1'b1, 1'b1, 4, -1);
        wait_cyc(IDLE_GAP);
        check("timeout_no_ready", 32'(ready_cnt - cnt0), 32'd0);
        check("timeout_state", 32'(dut.state), 32'(ST_IDLE));
        check("timeout_byte_held", 32'(byte_read), 32'hF4);
        send_frame(8'hFA, 1'b1, 1'b1, 11, -1);
        wait_cyc(30);
        check("post_timeout_ready_count", 32'(ready_cnt - cnt0), 32'd1);
        check("post_timeout_byte", 32'(byte_read), 32'hFA);
        check("post_timeout_err", 32'(byte_err), 32'h0);

        // READ_ENABLE dropped after the start bit must not abort the frame.
        cnt0 = ready_cnt;
        send_frame(8'h6B, 1'b0, 1'b1, 11, 3);
        wait_cyc(30);
        check("re_drop_ready_count", 32'(ready_cnt - cnt0), 32'd1);
        check("re_drop_byte", 32'(byte_read), 32'h6B);
        check("re_drop_err", 32'(byte_err), 32'h0);
        re = 1'b1;

        check("ready_pulse_width", 32'(wide_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
